// File: rtl/div_meter_pkg.sv
// Shared types and defaults for the divided-clock meter and related clock monitors.
package div_meter_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        LOST
    } meter_state_e;

    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1000;

endpackage

// File: rtl/clk_div_meter_if.sv
// Measurement bundle: divided clock in, period/high-time results and status out.
interface clk_div_meter_if
    import div_meter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             clk_lost;
    logic             mismatch;

    // master drives the clock under test and consumes results; slave is the meter
    modport master (output sig_in,
                    input  period, high_time, meas_valid, locked, clk_lost, mismatch);
    modport slave  (input  sig_in,
                    output period, high_time, meas_valid, locked, clk_lost, mismatch);
endinterface

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and flags its rising/falling edges.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;
    logic              s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            s_d   <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~s_d;
    assign fall = ~chain[STAGES-1] & s_d;
endmodule

// File: rtl/clk_div_meter.sv
// Measures period and high time of a divided clock in clk cycles, flags loss of it.
// Define DIV_METER_CHECK_EN to compare each period against EXP_PERIOD.
module clk_div_meter
    import div_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int EXP_PERIOD  = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_meter_if.slave mif
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (TIMEOUT >= (2 ** CNT_W) - 1 || EXP_PERIOD < 0) begin : g_bad_cfg
        $error("TIMEOUT must be below counter saturation, EXP_PERIOD non-negative");
    end

    logic             rise, fall;
    logic [CNT_W-1:0] cnt, hi_cap;
    logic             fall_seen;
    meter_state_e     state, state_nxt;
    logic             meas_fire, lost_entry;
    logic [CNT_W-1:0] period_q, high_q;
    logic             valid_q, locked_q;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (mif.sig_in),
        .rise  (rise),
        .fall  (fall)
    );

    // Counter restarts at 1 on each rise so its value at the next rise is the period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            hi_cap    <= '0;
            fall_seen <= 1'b0;
        end else begin
            if (rise)                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (fall) hi_cap <= cnt;
            if (rise)      fall_seen <= 1'b0;
            else if (fall) fall_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FIRST;
        else        state <= state_nxt;
    end

    // A rise always beats a coincident timeout.
    always_comb begin
        state_nxt = state;
        meas_fire = 1'b0;
        case (state)
            WAIT_FIRST: begin
                if (rise)                state_nxt = MEASURE;
                else if (cnt == TO_CNT)  state_nxt = LOST;
            end
            MEASURE: begin
                if (rise)                meas_fire = fall_seen;
                else if (cnt == TO_CNT)  state_nxt = LOST;
            end
            LOST: begin
                if (rise)                state_nxt = MEASURE;
            end
            default:                     state_nxt = WAIT_FIRST;
        endcase
        lost_entry = (state != LOST) && (state_nxt == LOST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= meas_fire;
            if (meas_fire) begin
                period_q <= cnt;
                high_q   <= hi_cap;
                locked_q <= 1'b1;
            end else if (lost_entry) begin
                locked_q <= 1'b0;
            end
        end
    end

`ifdef DIV_METER_CHECK_EN
    logic mismatch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          mismatch_q <= 1'b0;
        else if (meas_fire)  mismatch_q <= (cnt != CNT_W'(EXP_PERIOD));
        else if (lost_entry) mismatch_q <= 1'b0;
    end

    assign mif.mismatch = mismatch_q;
`else
    assign mif.mismatch = 1'b0;
`endif

    assign mif.period     = period_q;
    assign mif.high_time  = high_q;
    assign mif.meas_valid = valid_q;
    assign mif.locked     = locked_q;
    assign mif.clk_lost   = (state == LOST);
endmodule
